// File: rtl/spu_lsu_pkg.sv
// Shared types and constants for the SPU load/store unit.
package spu_lsu_pkg;

  typedef enum logic [2:0] {
    NOP  = 3'd0,
    LQD  = 3'd1,
    LQX  = 3'd2,
    LQA  = 3'd3,
    STQD = 3'd4,
    STQX = 3'd5,
    STQA = 3'd6
  } lsu_op_e;

  localparam int QW_BYTES   = 16;
  localparam int QW_SHIFT   = 4;
  localparam int REG_ADDR_W = 7;

  function automatic logic op_is_load(lsu_op_e op);
    return (op == LQD) || (op == LQX) || (op == LQA);
  endfunction

  function automatic logic op_is_store(lsu_op_e op);
    return (op == STQD) || (op == STQX) || (op == STQA);
  endfunction

endpackage

// File: rtl/lsu_ea_calc.sv
// Combinational effective-address generation: d-form, x-form and a-form
// addressing, then wrap to local-store size and quadword alignment.
module lsu_ea_calc
  import spu_lsu_pkg::*;
#(
  parameter int LS_ADDR_W = 15
) (
  input  logic [2:0]           op,
  input  logic [31:0]          ra_w0,
  input  logic [31:0]          rb_w0,
  input  logic [15:0]          imm,
  input  logic [31:0]          lslr,
  output logic [LS_ADDR_W-1:0] lsa
);

  logic [31:0] ea;
  logic [31:0] masked;
  logic        unused_hi;

  always_comb begin
    ea = '0;
    case (lsu_op_e'(op))
      LQD, STQD: ea = ra_w0 + ({{22{imm[9]}}, imm[9:0]} << QW_SHIFT);
      LQX, STQX: ea = ra_w0 + rb_w0;
      LQA, STQA: ea = {{16{imm[15]}}, imm} << 2;
      default:   ea = '0;
    endcase
  end

  // Bits above the local-store width are already zero after the LSLR mask.
  assign masked    = ea & lslr & ~32'hF;
  assign lsa       = masked[LS_ADDR_W-1:0];
  assign unused_hi = ^masked[31:LS_ADDR_W];

endmodule

// File: rtl/load_store_unit.sv
// Pipelined SPU load/store unit: issue -> stage A (memory access) -> stage B
// (read return) -> writeback. Define LSU_BOUNDS_CHECK_EN to fault accesses
// beyond the physically present local-store depth.
module load_store_unit
  import spu_lsu_pkg::*;
#(
  parameter int LS_ADDR_W   = 15,
  parameter int LS_QW_DEPTH = 2001
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_op,
  input  logic [127:0]          in_ra,
  input  logic [127:0]          in_rb,
  input  logic [127:0]          in_rt,
  input  logic [15:0]           in_imm,
  input  logic [REG_ADDR_W-1:0] in_rt_addr,
  input  logic                  flush,
  output logic [127:0]          mem_address,
  output logic [127:0]          mem_write_data,
  output logic                  mem_write,
  output logic                  mem_read,
  input  logic [127:0]          mem_read_data,
  output logic                  wb_valid,
  output logic [REG_ADDR_W-1:0] wb_rt_addr,
  output logic [127:0]          wb_data,
  output logic                  lsu_fault
);

  localparam logic [31:0] LSLR = 32'((64'd1 << LS_ADDR_W) - 64'd1);

  logic [LS_ADDR_W-1:0]  lsa;
  logic                  accept, issue_ld, issue_st;

  logic                  a_valid, a_is_load, a_oob;
  logic [LS_ADDR_W-1:0]  a_lsa;
  logic [127:0]          a_data;
  logic [REG_ADDR_W-1:0] a_rt;

  logic                  b_valid, b_fault;
  logic [REG_ADDR_W-1:0] b_rt;
  logic                  unused_ops;

  lsu_ea_calc #(.LS_ADDR_W(LS_ADDR_W)) u_ea (
    .op    (in_op),
    .ra_w0 (in_ra[127:96]),
    .rb_w0 (in_rb[127:96]),
    .imm   (in_imm),
    .lslr  (LSLR),
    .lsa   (lsa)
  );

  // Only the preferred word of RA/RB participates in addressing.
  assign unused_ops = ^{in_ra[95:0], in_rb[95:0]};

  assign in_ready = !flush;
  assign accept   = in_valid && in_ready;
  assign issue_ld = accept && op_is_load(lsu_op_e'(in_op));
  assign issue_st = accept && op_is_store(lsu_op_e'(in_op));

`ifdef LSU_BOUNDS_CHECK_EN
  assign a_oob = a_valid && ((32'(a_lsa) >> QW_SHIFT) >= 32'(LS_QW_DEPTH));
`else
  assign a_oob = 1'b0;
`endif

  // Flush and out-of-bounds both gate the access in the stage-A cycle itself.
  assign mem_write      = a_valid && !a_is_load && !flush && !a_oob;
  assign mem_read       = a_valid &&  a_is_load && !flush && !a_oob;
  assign mem_address    = 128'(a_lsa);
  assign mem_write_data = mem_write ? a_data : '0;
  assign lsu_fault      = a_oob && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_valid    <= 1'b0;
      a_is_load  <= 1'b0;
      a_lsa      <= '0;
      a_data     <= '0;
      a_rt       <= '0;
      b_valid    <= 1'b0;
      b_fault    <= 1'b0;
      b_rt       <= '0;
      wb_valid   <= 1'b0;
      wb_data    <= '0;
      wb_rt_addr <= '0;
    end else begin
      // flush forces in_ready low, so no issue can land in stage A with it.
      a_valid <= issue_ld || issue_st;
      if (issue_ld || issue_st) begin
        a_is_load <= issue_ld;
        a_lsa     <= lsa;
        a_data    <= in_rt;
        a_rt      <= in_rt_addr;
      end
      // Faulting loads still travel to writeback, carrying zero data.
      b_valid    <= a_valid && a_is_load && !flush;
      b_fault    <= a_oob;
      b_rt       <= a_rt;
      wb_valid   <= b_valid && !flush;
      wb_data    <= b_fault ? '0 : mem_read_data;
      wb_rt_addr <= b_rt;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random
// traffic against an op-level reference model with a shadow local store.
module tb_load_store_unit;
  import spu_lsu_pkg::*;

  localparam int LS_ADDR_W   = 15;
  localparam int LS_QW_DEPTH = 2001;
`ifdef LSU_BOUNDS_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  logic         clk, reset;
  logic         in_valid, in_ready, flush;
  logic [2:0]   in_op;
  logic [127:0] in_ra, in_rb, in_rt;
  logic [15:0]  in_imm;
  logic [6:0]   in_rt_addr;
  logic [127:0] mem_address, mem_write_data, mem_read_data;
  logic         mem_write, mem_read;
  logic         wb_valid, lsu_fault;
  logic [6:0]   wb_rt_addr;
  logic [127:0] wb_data;

  load_store_unit #(.LS_ADDR_W(LS_ADDR_W), .LS_QW_DEPTH(LS_QW_DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_ra(in_ra), .in_rb(in_rb), .in_rt(in_rt),
    .in_imm(in_imm), .in_rt_addr(in_rt_addr), .flush(flush),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write(mem_write), .mem_read(mem_read), .mem_read_data(mem_read_data),
    .wb_valid(wb_valid), .wb_rt_addr(wb_rt_addr), .wb_data(wb_data),
    .lsu_fault(lsu_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory with registered read port, full 32 KB local store.
  logic [127:0] mem [0:2047];
  always @(posedge clk) begin
    if (mem_write) mem[mem_address[LS_ADDR_W-1:4]] <= mem_write_data;
    if (mem_read)  mem_read_data <= mem[mem_address[LS_ADDR_W-1:4]];
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: shadow memory plus the op sitting at its memory edge,
  // the load awaiting writeback, and the writeback currently presented.
  logic [127:0] ref_mem [0:2047];
  bit           sa_v, sa_ld, sa_oob, sb_v, wbv;
  int unsigned  sa_lsa;
  logic [127:0] sa_data, sb_data, wbdata;
  logic [6:0]   sa_rt, sb_rt, wbrt;

  function automatic int unsigned ref_lsa(input logic [2:0] op, input logic [31:0] ra,
                                          input logic [31:0] rb, input logic [15:0] imm);
    int unsigned ea;
    case (op)
      3'd1, 3'd4: ea = ra + int'($signed(imm[9:0])) * 16;
      3'd2, 3'd5: ea = ra + rb;
      3'd3, 3'd6: ea = int'($signed(imm)) * 4;
      default:    ea = 0;
    endcase
    return ea % (1 << LS_ADDR_W) / 16 * 16;
  endfunction

  task automatic model_clear();
    sa_v = 0; sa_ld = 0; sa_oob = 0; sa_lsa = 0; sa_data = '0; sa_rt = '0;
    sb_v = 0; sb_data = '0; sb_rt = '0;
    wbv = 0; wbdata = '0; wbrt = '0;
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_mem_write"}, mem_write, 0);
    chk({p, "_mem_read"}, mem_read, 0);
    chk({p, "_mem_address"}, mem_address, 0);
    chk({p, "_mem_wdata"}, mem_write_data, 0);
    chk({p, "_wb_valid"}, wb_valid, 0);
    chk({p, "_wb_data"}, wb_data, 0);
    chk({p, "_wb_rt_addr"}, wb_rt_addr, 0);
    chk({p, "_lsu_fault"}, lsu_fault, 0);
  endtask

  // One clock cycle: drive, check stage-A outputs, clock, check writeback.
  task automatic cycle(input bit v, input logic [2:0] op, input logic [31:0] ra,
                       input logic [31:0] rb, input logic [127:0] rt,
                       input logic [15:0] imm, input logic [6:0] rta, input bit fl);
    bit exp_rd, exp_wr;
    in_valid = v; in_op = op; in_rt = rt; in_imm = imm; in_rt_addr = rta; flush = fl;
    in_ra = {ra, $urandom(), $urandom(), $urandom()};
    in_rb = {rb, $urandom(), $urandom(), $urandom()};
    #1;
    exp_rd = sa_v &&  sa_ld && !fl && !(BC && sa_oob);
    exp_wr = sa_v && !sa_ld && !fl && !(BC && sa_oob);
    chk("in_ready", in_ready, !fl);
    chk("mem_read", mem_read, exp_rd);
    chk("mem_write", mem_write, exp_wr);
    chk("lsu_fault", lsu_fault, BC && sa_v && sa_oob && !fl);
    if (sa_v) chk("mem_address", mem_address, 128'(sa_lsa));
    chk("mem_write_data", mem_write_data, exp_wr ? sa_data : 128'h0);
    @(posedge clk);
    wbv = sb_v && !fl; wbrt = sb_rt; wbdata = sb_data;
    sb_v = sa_v && sa_ld && !fl; sb_rt = sa_rt;
    sb_data = (BC && sa_oob) ? 128'h0 : ref_mem[sa_lsa / 16];
    if (exp_wr) ref_mem[sa_lsa / 16] = sa_data;
    sa_v = v && !fl && (op inside {[3'd1:3'd6]});
    sa_ld = op inside {3'd1, 3'd2, 3'd3};
    sa_lsa = ref_lsa(op, ra, rb, imm);
    sa_oob = (sa_lsa / 16) >= LS_QW_DEPTH;
    sa_data = rt; sa_rt = rta;
    @(negedge clk);
    chk("wb_valid", wb_valid, wbv);
    if (wbv) begin
      chk("wb_data", wb_data, wbdata);
      chk("wb_rt_addr", wb_rt_addr, wbrt);
    end
  endtask

  task automatic idle(input bit fl);
    cycle(0, 3'd0, 0, 0, '0, 16'h0, 7'd0, fl);
  endtask

  initial begin
    logic [127:0] pat;
    for (int i = 0; i < 2048; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    mem_read_data = '0;
    model_clear();
    reset = 1'b1; in_valid = 0; in_op = 0; in_ra = '0; in_rb = '0; in_rt = '0;
    in_imm = '0; in_rt_addr = '0; flush = 0;
    #1;
    chk_zero("rst");
    chk("rst_in_ready", in_ready, 1);
    flush = 1; #1; chk("rst_in_ready_fl", in_ready, 0); flush = 0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Store then load of the same d-form address.
    pat = {16{8'hA5}};
    cycle(1, STQD, 32'h100, 0, pat, 16'd2, 7'd0, 0);
    chk("stqd_we", mem_write, 1);
    chk("stqd_addr", mem_address, 128'h120);
    cycle(1, LQD, 32'h100, 0, '0, 16'd2, 7'd5, 0);
    idle(0); idle(0);
    chk("lqd_wb_valid", wb_valid, 1);
    chk("lqd_wb_data", wb_data, pat);
    chk("lqd_wb_rt", wb_rt_addr, 128'd5);

    // x-form sum and d-form negative wrap.
    cycle(1, LQX, 32'h1007, 32'h9, '0, 16'h0, 7'd3, 0);
    chk("lqx_addr", mem_address, 128'h1010);
    cycle(1, LQD, 32'h0, 0, '0, 16'h03FF, 7'd4, 0);
    chk("wrap_addr", mem_address, 128'h7FF0);
    idle(0); idle(0);

    // a-form to the top quadword, beyond the physical depth.
    cycle(1, LQA, 0, 0, '0, 16'hFFFF, 7'd6, 0);
    chk("lqa_addr", mem_address, 128'h7FF0);
    chk("lqa_rd", mem_read, !BC);
    chk("lqa_fault", lsu_fault, BC);
    idle(0); idle(0);

    // Back-to-back stores then back-to-back loads.
    cycle(1, STQA, 0, 0, 128'd1, 16'd0, 7'd0, 0);
    cycle(1, STQA, 0, 0, 128'd2, 16'd4, 7'd0, 0);
    cycle(1, STQA, 0, 0, 128'd3, 16'd8, 7'd0, 0);
    cycle(1, LQA, 0, 0, '0, 16'd0, 7'd10, 0);
    cycle(1, LQA, 0, 0, '0, 16'd4, 7'd11, 0);
    cycle(1, LQA, 0, 0, '0, 16'd8, 7'd12, 0);
    chk("b2b_wb1", wb_data, 128'd1);
    idle(0); chk("b2b_wb2", wb_data, 128'd2);
    idle(0); chk("b2b_wb3", wb_data, 128'd3);
    idle(0); idle(0);

    // Flush with a load in stage A, then in stage B.
    cycle(1, LQA, 0, 0, '0, 16'd4, 7'd20, 0);
    idle(1); idle(0); idle(0);
    cycle(1, LQA, 0, 0, '0, 16'd4, 7'd21, 0);
    idle(0); idle(1); idle(0); idle(0);
    // Store killed by flush must not reach memory.
    cycle(1, STQA, 0, 0, 128'hDEAD, 16'h40, 7'd0, 0);
    idle(1);
    cycle(1, LQA, 0, 0, '0, 16'h40, 7'd22, 0);
    idle(0); idle(0);

    // Asynchronous reset while a store sits in stage A.
    cycle(1, STQA, 0, 0, 128'hBEEF, 16'h50, 7'd0, 0);
    in_valid = 0; #1;
    chk("pre_rst_we", mem_write, 1);
    reset = 1'b1; #1;
    chk_zero("midrst");
    model_clear();
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    chk("rst_mem_kept", mem[20], 128'h0);
    cycle(1, LQA, 0, 0, '0, 16'h50, 7'd23, 0);
    idle(0); idle(0);

    // Random traffic, addresses clustered so loads revisit stored quadwords.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ra, rb;
      logic [15:0] imm;
      ra  = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, 31)) << 4;
      rb  = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, 15)) << 4;
      imm = ($urandom_range(0, 7) == 0) ? 16'($urandom()) : 16'($urandom_range(0, 40));
      cycle($urandom_range(0, 9) < 8, 3'($urandom_range(0, 7)), ra, rb,
            {$urandom(), $urandom(), $urandom(), $urandom()}, imm,
            7'($urandom_range(0, 127)), $urandom_range(0, 9) == 0);
    end
    idle(0); idle(0); idle(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Pipelined SPU load/store unit sitting directly upstream of the quadword-addressed local-store data memory. It accepts one issued load/store per cycle and computes the effective local-store address from register operands and immediates. It drives the data memory's address, write-data, write-enable and read-enable ports, then captures the registered read data and returns it as a register-file writeback. It owns quadword alignment, address wrap to local-store size, flush of in-flight loads and optional bounds checking.

## Interface
- LS_ADDR_W, 15: local-store byte-address width; local-store limit mask LSLR = 2^LS_ADDR_W - 1.
- LS_QW_DEPTH, 2001: number of quadwords physically present in data memory; used only by the bounds check.
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- in_valid  in  1  issue valid.
- in_ready  out  1  equals !flush; an issue is accepted when in_valid && in_ready at a rising edge.
- in_op  in  3  lsu_op_e: NOP, LQD, LQX, LQA, STQD, STQX, STQA.
- in_ra  in  128  RA value; preferred word is bits [127:96].
- in_rb  in  128  RB value (x-form only); preferred word is bits [127:96].
- in_rt  in  128  store data (stores only).
- in_imm  in  16  I10 in bits [9:0] for d-form, I16 for a-form.
- in_rt_addr  in  7  load destination register.
- flush  in  1  kill all in-flight operations.
- mem_address  out  128  byte address to data memory; zero-extended from LS_ADDR_W bits.
- mem_write_data  out  128  store data.
- mem_write, mem_read  out  1 each  data memory enables.
- mem_read_data  in  128  registered data-memory output, valid one edge after mem_read.
- wb_valid  out  1  load writeback valid (one-cycle pulse per load).
- wb_rt_addr  out  7  writeback register.
- wb_data  out  128  loaded quadword.
- lsu_fault  out  1  bounds-check pulse; tied to 0 when LSU_BOUNDS_CHECK_EN is undefined.

## Operation
- Effective address (EA), 32-bit arithmetic with wrap:
  - LQD/STQD: EA = RA.w0 + (sext(I10) << 4).
  - LQX/STQX: EA = RA.w0 + RB.w0.
  - LQA/STQA: EA = sext(I16) << 2.
- Final address: LSA = EA & LSLR & ~32'hF. The low 4 bits are always zero and the address wraps modulo 2^LS_ADDR_W.
- NOP, or in_valid low, is accepted but creates no stage-A valid.
- Stage A (access) registers: a_valid, a_is_load, a_lsa, a_data, a_rt. Combinational outputs from stage A:
  - mem_write = a_valid && store && !flush.
  - mem_read = a_valid && load && !flush.
  - mem_address = a_lsa.
  - mem_write_data = a_data when mem_write is high, else 0.
- Stage B (return) registers: b_valid = stage-A load that issued mem_read; b_rt.
- Writeback registers:
  - wb_valid <= b_valid && !flush.
  - wb_data <= mem_read_data.
  - wb_rt_addr <= b_rt.
- flush:
  - Suppresses the stage-A memory access in the same cycle.
  - Clears stage A, stage B and wb_valid at the next edge.
  - A concurrent issue is refused (in_ready is low).
- Back-to-back operations are supported. Store at edge N followed by load of the same LSA at edge N+1 returns the new data, because the memory write lands before the read edge.
- Reset values: every register is 0, so wb_valid=0, wb_data=0, wb_rt_addr=0, mem_write=0, mem_read=0, mem_address=0, mem_write_data=0, lsu_fault=0. in_ready follows flush.
- Reset asserted mid-operation drops every in-flight op. A pending store never reaches memory, and no writeback occurs.

## Timing
- Issue accepted at edge E0.
- Store: memory written at E1.
- Load:
  - mem_read is high in cycle E0–E1.
  - Memory data is valid after E1.
  - wb_valid is high in cycle E2–E3.
  - Load-to-use latency is 2 edges.
- Throughput: one operation per cycle; no stalls other than flush.

## Configuration
- LSU_BOUNDS_CHECK_EN defined: an access with (LSA >> 4) >= LS_QW_DEPTH is handled as follows.
  - mem_write and mem_read stay low.
  - lsu_fault pulses for the stage-A cycle.
  - A faulting load still produces wb_valid at E2 with wb_data = 0.
- Undefined: no check; every address goes to memory; lsu_fault = 0.

## Structure
- Package spu_lsu_pkg holds:
  - lsu_op_e enum.
  - QW_BYTES = 16, QW_SHIFT = 4.
  - REG_ADDR_W = 7.
- Sub-module lsu_ea_calc: combinational EA/LSA generation from op, RA, RB, imm and LSLR.

## Test plan
- STQD RA.w0=0x100, I10=2, rt=128'hA5A5…A5:
  - mem_write at E0–E1 with mem_address 0x120.
  - Following LQD with identical operands → wb_valid at E2 with wb_data 128'hA5A5…A5 and correct wb_rt_addr.
- LQX RA.w0=0x1007, RB.w0=0x9 → mem_address 0x1010; I10=0x3FF (−1) with RA.w0=0 → wraps to 0x7FF0.
- LQA I16=0xFFFF → LSA 0x7FF0 (qw 2047):
  - With LSU_BOUNDS_CHECK_EN: no mem_read, lsu_fault pulse, wb_data 0.
  - Without it: mem_read asserted.
- Three back-to-back loads to 0x0, 0x10, 0x20 after stores of 1, 2, 3 → wb pulses on consecutive cycles with data 1, 2, 3.
- Flush:
  - flush in the cycle a load sits in stage A → no mem_read, no wb_valid.
  - flush when the load is in stage B → mem_read was seen, but no wb_valid.
  - Store under flush in stage A → memory unchanged.
- Reset asserted between E0 and E1 of a store → mem_write drops asynchronously, memory unchanged, all outputs 0.
